// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI retirement monitor.
//   mon_state_t : monitor FSM states
//   err_code_t  : failure codes latched into err_code (lower value wins)
//   ORDER_W     : width of rvfi_order / retire counters
package rvfi_mon_pkg;

  localparam int ORDER_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, ERROR} mon_state_t;

  typedef enum logic [2:0] {
    NONE, ORDER, PC_CHAIN, LANE_GAP, POST_HALT, TIMEOUT, PC_ALIGN
  } err_code_t;

endpackage

// File: rtl/rvfi_retire_monitor_if.sv
// RVFI retirement bundle, NRET lanes wide.
//   master : the core (or bench) driving retirements
//   slave  : the monitor observing them
interface rvfi_retire_monitor_if #(
  parameter int NRET = 1,
  parameter int XLEN = 32
);
  logic [NRET-1:0]                              rvfi_valid;
  logic [NRET-1:0][rvfi_mon_pkg::ORDER_W-1:0]   rvfi_order;
  logic [NRET-1:0][XLEN-1:0]                    rvfi_pc_rdata;
  logic [NRET-1:0][XLEN-1:0]                    rvfi_pc_wdata;
  logic [NRET-1:0]                              rvfi_trap;
  logic [NRET-1:0]                              rvfi_halt;
  logic [NRET-1:0]                              rvfi_intr;

  modport master (output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata,
                         rvfi_trap, rvfi_halt, rvfi_intr);
  modport slave  (input  rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata,
                         rvfi_trap, rvfi_halt, rvfi_intr);
endinterface

// File: rtl/rvfi_mon_lane_check.sv
// Combinational checks for a single retirement lane.
//   valid/order/pc_rdata/pc_wdata/trap/intr : lane signals
//   exp_order  : order this lane must carry
//   prev_pc    : pc_wdata of the previous retirement
//   prev_vld   : a previous retirement exists (chain check enabled)
//   fail_*     : per-code failure bits (only raised on valid lanes)
module rvfi_mon_lane_check
  import rvfi_mon_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int COMPRESSED = 1
)(
  input  logic               valid,
  input  logic [ORDER_W-1:0] order,
  input  logic [ORDER_W-1:0] exp_order,
  input  logic [XLEN-1:0]    pc_rdata,
  input  logic [XLEN-1:0]    pc_wdata,
  input  logic [XLEN-1:0]    prev_pc,
  input  logic               prev_vld,
  input  logic               trap,
  input  logic               intr,
  output logic               fail_order,
  output logic               fail_chain,
  output logic               fail_align
);

  logic misalign;

  // 2-byte alignment is legal only with the compressed extension
  assign misalign   = (COMPRESSED != 0) ? pc_wdata[0] : (|pc_wdata[1:0]);

  assign fail_order = valid && (order != exp_order);
  // a handler entry legitimately breaks the PC chain
  assign fail_chain = valid && prev_vld && !intr && (pc_rdata != prev_pc);
  assign fail_align = valid && !trap && misalign;

endmodule

// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement stream checker (NRET lanes).
// Checks order continuity, PC chaining, lane packing, post-halt silence,
// PC alignment and a retirement watchdog; latches the first failure.
//   clk, reset_n : clock, async active-low reset
//   rvfi         : retirement bundle (slave modport)
//   err          : sticky failure flag (registered)
//   err_code     : code of the first failure
//   err_order    : rvfi_order of the first failing lane (0 for timeout)
//   retired      : count of valid retirements since reset
// Optional: define RVFI_MON_ASSERT_EN to add an immediate assert on the
// failure condition and a cover on the HALTED state.
module rvfi_retire_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int NRET       = 1,
  parameter int XLEN       = 32,
  parameter int COMPRESSED = 1,
  parameter int TIMEOUT    = 64
)(
  input  logic                 clk,
  input  logic                 reset_n,
  rvfi_retire_monitor_if.slave rvfi,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [ORDER_W-1:0]   err_order,
  output logic [ORDER_W-1:0]   retired
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mon_state_t         state_q, state_d;
  logic [ORDER_W-1:0] exp_order_q;
  logic [XLEN-1:0]    last_pc_q;
  logic [WD_W-1:0]    wdog_q;

  logic [NRET-1:0]         f_order, f_chain, f_gap, f_halt, f_align;
  logic [NRET:0][XLEN-1:0] prev_pc;    // [i] = pc_wdata of retirement before lane i
  logic [NRET-1:0]         prev_vld;
  logic [NRET:0]           halt_seen;  // [i] = valid halt on some lane below i
  logic                    f_tmo;
  logic                    any_vld;
  logic [ORDER_W-1:0]      nvld;
  err_code_t               code_d;
  logic [ORDER_W-1:0]      ord_d;
  logic                    err_next;

  assign prev_pc[0]   = last_pc_q;
  assign halt_seen[0] = 1'b0;

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    if (i == 0) begin : g_l0
      assign prev_vld[i] = (state_q != IDLE);
      assign f_gap[i]    = 1'b0;
    end else begin : g_ln
      assign prev_vld[i] = prev_vld[i-1] | rvfi.rvfi_valid[i-1];
      assign f_gap[i]    = rvfi.rvfi_valid[i] & ~rvfi.rvfi_valid[i-1];
    end

    rvfi_mon_lane_check #(.XLEN(XLEN), .COMPRESSED(COMPRESSED)) u_chk (
      .valid      (rvfi.rvfi_valid[i]),
      .order      (rvfi.rvfi_order[i]),
      .exp_order  (exp_order_q + ORDER_W'(i)),
      .pc_rdata   (rvfi.rvfi_pc_rdata[i]),
      .pc_wdata   (rvfi.rvfi_pc_wdata[i]),
      .prev_pc    (prev_pc[i]),
      .prev_vld   (prev_vld[i]),
      .trap       (rvfi.rvfi_trap[i]),
      .intr       (rvfi.rvfi_intr[i]),
      .fail_order (f_order[i]),
      .fail_chain (f_chain[i]),
      .fail_align (f_align[i])
    );

    assign prev_pc[i+1]   = rvfi.rvfi_valid[i] ? rvfi.rvfi_pc_wdata[i] : prev_pc[i];
    assign halt_seen[i+1] = halt_seen[i] | (rvfi.rvfi_valid[i] & rvfi.rvfi_halt[i]);
    assign f_halt[i]      = rvfi.rvfi_valid[i] & ((state_q == HALTED) | halt_seen[i]);
  end

  assign any_vld = |rvfi.rvfi_valid;
  assign f_tmo   = (TIMEOUT != 0) && (state_q == RUN) && (wdog_q == WD_W'(TIMEOUT));

  always_comb begin
    nvld = '0;
    for (int i = 0; i < NRET; i++) nvld = nvld + ORDER_W'(rvfi.rvfi_valid[i]);
  end

  // Priority: scan highest code first and lanes high-to-low so that the
  // last write is the lowest code on the lowest lane.
  always_comb begin
    code_d = NONE;
    ord_d  = '0;
    for (int i = NRET-1; i >= 0; i--)
      if (f_align[i]) begin code_d = PC_ALIGN; ord_d = rvfi.rvfi_order[i]; end
    if (f_tmo) begin code_d = rvfi_mon_pkg::TIMEOUT; ord_d = '0; end
    for (int i = NRET-1; i >= 0; i--)
      if (f_halt[i]) begin code_d = POST_HALT; ord_d = rvfi.rvfi_order[i]; end
    for (int i = NRET-1; i >= 0; i--)
      if (f_gap[i]) begin code_d = LANE_GAP; ord_d = rvfi.rvfi_order[i]; end
    for (int i = NRET-1; i >= 0; i--)
      if (f_chain[i]) begin code_d = PC_CHAIN; ord_d = rvfi.rvfi_order[i]; end
    for (int i = NRET-1; i >= 0; i--)
      if (f_order[i]) begin code_d = ORDER; ord_d = rvfi.rvfi_order[i]; end
  end

  assign err_next = (state_q != ERROR) && (code_d != NONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_vld) state_d = halt_seen[NRET] ? HALTED : RUN;
      RUN:     if (halt_seen[NRET]) state_d = HALTED;
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (err_next) state_d = ERROR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      exp_order_q <= '0;
      last_pc_q   <= '0;
      wdog_q      <= '0;
      err         <= 1'b0;
      err_code    <= '0;
      err_order   <= '0;
      retired     <= '0;
    end else begin
      state_q <= state_d;
      // the detecting cycle still counts; nothing counts once in ERROR
      if (state_q != ERROR) retired <= retired + nvld;
      if (err_next) begin
        err       <= 1'b1;
        err_code  <= code_d;
        err_order <= ord_d;
      end else if (state_q != ERROR) begin
        exp_order_q <= exp_order_q + nvld;
        last_pc_q   <= prev_pc[NRET];
      end
      if (state_q != RUN || any_vld) wdog_q <= '0;
      else if (wdog_q != WD_W'(TIMEOUT)) wdog_q <= wdog_q + 1'b1;
    end
  end

`ifdef RVFI_MON_ASSERT_EN
  always_comb begin
    if (reset_n) begin
      assert (!err_next);
      cover (state_q == HALTED);
    end
  end
`else
  // flag-only build: failures are reported solely through the outputs
`endif

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
module tb_rvfi_retire_monitor;
  logic clk;
  logic rst_n;

  logic        err1, err4;
  logic [2:0]  code1, code4;
  logic [63:0] ord1, ord4, ret1_cnt, ret4_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  rvfi_retire_monitor_if #(.NRET(1), .XLEN(32)) if1 ();
  rvfi_retire_monitor_if #(.NRET(4), .XLEN(32)) if4 ();

  rvfi_retire_monitor #(.NRET(1), .XLEN(32), .COMPRESSED(1), .TIMEOUT(64)) dut1 (
    .clk(clk), .reset_n(rst_n), .rvfi(if1.slave),
    .err(err1), .err_code(code1), .err_order(ord1), .retired(ret1_cnt));

  rvfi_retire_monitor #(.NRET(4), .XLEN(32), .COMPRESSED(1), .TIMEOUT(64)) dut4 (
    .clk(clk), .reset_n(rst_n), .rvfi(if4.slave),
    .err(err4), .err_code(code4), .err_order(ord4), .retired(ret4_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // one retirement on the single-lane monitor
  task automatic ret1(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw,
                      input logic h, input logic tr);
    if1.rvfi_valid    = 1'b1;
    if1.rvfi_order    = ord;
    if1.rvfi_pc_rdata = pcr;
    if1.rvfi_pc_wdata = pcw;
    if1.rvfi_halt     = h;
    if1.rvfi_trap     = tr;
    if1.rvfi_intr     = 1'b0;
    tick();
    if1.rvfi_valid = 1'b0;
  endtask

  task automatic clr4();
    if4.rvfi_valid    = '0;
    if4.rvfi_order    = '0;
    if4.rvfi_pc_rdata = '0;
    if4.rvfi_pc_wdata = '0;
    if4.rvfi_trap     = '0;
    if4.rvfi_halt     = '0;
    if4.rvfi_intr     = '0;
  endtask

  task automatic lane4(input int i, input logic [63:0] ord, input logic [31:0] pcr,
                       input logic [31:0] pcw, input logic h, input logic it);
    if4.rvfi_valid[i]    = 1'b1;
    if4.rvfi_order[i]    = ord;
    if4.rvfi_pc_rdata[i] = pcr;
    if4.rvfi_pc_wdata[i] = pcw;
    if4.rvfi_halt[i]     = h;
    if4.rvfi_intr[i]     = it;
  endtask

  initial begin
    rst_n = 1'b0;
    if1.rvfi_valid = '0; if1.rvfi_order = '0; if1.rvfi_pc_rdata = '0;
    if1.rvfi_pc_wdata = '0; if1.rvfi_trap = '0; if1.rvfi_halt = '0; if1.rvfi_intr = '0;
    clr4();
    tick(); tick();
    chk("rst_err",     {63'd0, err1}, 64'd0);
    chk("rst_code",    {61'd0, code1}, 64'd0);
    chk("rst_order",   ord1, 64'd0);
    chk("rst_retired", ret1_cnt, 64'd0);
    rst_n = 1'b1;

    // clean chained stream, orders 0..9
    for (int i = 0; i < 10; i++) ret1(64'(i), 32'(i*4), 32'(i*4 + 4), 1'b0, 1'b0);
    chk("seq_err",     {63'd0, err1}, 64'd0);
    chk("seq_retired", ret1_cnt, 64'd10);

    // order skip 0,1,3
    do_reset();
    ret1(64'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    ret1(64'd1, 32'h4, 32'h8, 1'b0, 1'b0);
    chk("skip_pre_err", {63'd0, err1}, 64'd0);
    ret1(64'd3, 32'h8, 32'hc, 1'b0, 1'b0);
    chk("skip_err",     {63'd0, err1}, 64'd1);
    chk("skip_code",    {61'd0, code1}, 64'd1);
    chk("skip_order",   ord1, 64'd3);
    chk("skip_retired", ret1_cnt, 64'd3);
    ret1(64'd4, 32'hc, 32'h10, 1'b0, 1'b0);
    chk("sticky_code",    {61'd0, code1}, 64'd1);
    chk("sticky_retired", ret1_cnt, 64'd3);

    // retirement after halt
    do_reset();
    for (int i = 0; i < 5; i++) ret1(64'(i), 32'(i*4), 32'(i*4 + 4), 1'b0, 1'b0);
    ret1(64'd5, 32'h14, 32'h18, 1'b1, 1'b0);
    chk("halt_ok_err", {63'd0, err1}, 64'd0);
    ret1(64'd6, 32'h18, 32'h1c, 1'b0, 1'b0);
    chk("posthalt_code",    {61'd0, code1}, 64'd4);
    chk("posthalt_order",   ord1, 64'd6);
    chk("posthalt_retired", ret1_cnt, 64'd7);

    // halt then silence: no watchdog
    do_reset();
    ret1(64'd0, 32'h0, 32'h4, 1'b1, 1'b0);
    repeat (200) tick();
    chk("halt_idle_err",     {63'd0, err1}, 64'd0);
    chk("halt_idle_retired", ret1_cnt, 64'd1);

    // watchdog: error 65 cycles after the last retirement
    do_reset();
    ret1(64'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    repeat (64) tick();
    chk("tmo_pre_err", {63'd0, err1}, 64'd0);
    tick();
    chk("tmo_err",   {63'd0, err1}, 64'd1);
    chk("tmo_code",  {61'd0, code1}, 64'd5);
    chk("tmo_order", ord1, 64'd0);

    // asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    chk("arst_err",     {63'd0, err1}, 64'd0);
    chk("arst_code",    {61'd0, code1}, 64'd0);
    chk("arst_retired", ret1_cnt, 64'd0);
    rst_n = 1'b1;
    ret1(64'd0, 32'h100, 32'h104, 1'b0, 1'b0);
    chk("arst_first_err", {63'd0, err1}, 64'd0);
    chk("arst_first_ret", ret1_cnt, 64'd1);
    ret1(64'd1, 32'h104, 32'h108, 1'b0, 1'b0);
    // trapping lane with odd target: alignment not checked
    ret1(64'd2, 32'h108, 32'h201, 1'b0, 1'b1);
    chk("trap_err",     {63'd0, err1}, 64'd0);
    chk("trap_retired", ret1_cnt, 64'd3);
    ret1(64'd3, 32'h201, 32'h203, 1'b0, 1'b0);
    chk("align_code",  {61'd0, code1}, 64'd6);
    chk("align_order", ord1, 64'd3);

    // 4-lane: PC chain break inside one cycle
    do_reset();
    clr4();
    lane4(0, 64'd0, 32'h100, 32'h102, 1'b0, 1'b0);
    lane4(1, 64'd1, 32'h104, 32'h106, 1'b0, 1'b0);
    tick(); clr4();
    chk("chain_code",    {61'd0, code4}, 64'd2);
    chk("chain_order",   ord4, 64'd1);
    chk("chain_retired", ret4_cnt, 64'd2);

    // same with interrupt entry on lane1, then a full 4-lane cycle
    do_reset();
    lane4(0, 64'd0, 32'h100, 32'h102, 1'b0, 1'b0);
    lane4(1, 64'd1, 32'h104, 32'h106, 1'b0, 1'b1);
    tick(); clr4();
    chk("intr_err",     {63'd0, err4}, 64'd0);
    chk("intr_retired", ret4_cnt, 64'd2);
    lane4(0, 64'd2, 32'h106, 32'h108, 1'b0, 1'b0);
    lane4(1, 64'd3, 32'h108, 32'h10a, 1'b0, 1'b0);
    lane4(2, 64'd4, 32'h10a, 32'h10c, 1'b0, 1'b0);
    lane4(3, 64'd5, 32'h10c, 32'h10e, 1'b0, 1'b0);
    tick(); clr4();
    chk("full_err",     {63'd0, err4}, 64'd0);
    chk("full_retired", ret4_cnt, 64'd6);

    // lane gap 0101
    do_reset();
    lane4(0, 64'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    lane4(2, 64'd2, 32'h4, 32'h8, 1'b0, 1'b0);
    tick(); clr4();
    chk("gap_code",  {61'd0, code4}, 64'd3);
    chk("gap_order", ord4, 64'd2);

    // lane gap plus order mismatch: ORDER wins
    do_reset();
    lane4(0, 64'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    lane4(2, 64'd7, 32'h4, 32'h8, 1'b0, 1'b0);
    tick(); clr4();
    chk("gapord_code",  {61'd0, code4}, 64'd1);
    chk("gapord_order", ord4, 64'd7);

    // valid lane above a halt lane in the same cycle
    do_reset();
    lane4(0, 64'd0, 32'h0, 32'h4, 1'b1, 1'b0);
    lane4(1, 64'd1, 32'h4, 32'h8, 1'b0, 1'b0);
    tick(); clr4();
    chk("halt_lane_code",  {61'd0, code4}, 64'd4);
    chk("halt_lane_order", ord4, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rvfi_retire_monitor.md
Name: rvfi_retire_monitor

Overview:
- Parametrised sequential checker on the RVFI retirement stream of the riscv core, instantiated beside the core in formal and simulation testbenches.
- Generalises the per-instruction ISA check to multi-retire (NRET lanes) and adds cross-instruction checks: order continuity, PC chaining, lane packing, post-halt silence, PC alignment and a liveness watchdog.
- Captures the first failure with code and order, and counts retired instructions.

Parameters:
- NRET, 1, retirement lanes per cycle (1..4)
- XLEN, 32, register/PC width
- COMPRESSED, 1, 1 = 2-byte PC alignment legal (RV32IMC); 0 = 4-byte alignment required
- TIMEOUT, 64, max consecutive cycles without retirement after first retirement; 0 disables the watchdog

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rvfi_valid  in  NRET  per-lane retire valid
- rvfi_order  in  64*NRET  per-lane retire index
- rvfi_pc_rdata  in  XLEN*NRET  per-lane PC of the instruction
- rvfi_pc_wdata  in  XLEN*NRET  per-lane next PC
- rvfi_trap  in  NRET  per-lane trap
- rvfi_halt  in  NRET  per-lane halt
- rvfi_intr  in  NRET  per-lane first-instruction-of-handler flag
- err  out  1  sticky failure flag
- err_code  out  3  first failure code
- err_order  out  64  rvfi_order of first failing retirement (0 for timeout)
- retired  out  64  total valid retirements since reset

Behaviour:
- Single clock; reset is asynchronous and active-low. All state clears on reset_n low, independent of clk: err=0, err_code=0, err_order=0, retired=0, state=IDLE, expected order=0, watchdog=0.
- States:
  - IDLE: no retirement yet. Watchdog inactive. Any valid retirement moves to RUN, or to HALTED if that retirement carries halt.
  - RUN: checks active and watchdog counting. A valid halt lane moves to HALTED.
  - HALTED: any valid lane is an error. Watchdog inactive.
  - ERROR: entered from any state on a detected failure. Absorbing until reset.
- All checks are evaluated on lanes in ascending index order. Only valid lanes are checked.
- Error codes:
  - 1 ORDER: lane i order != exp_order + i.
  - 2 PC_CHAIN: pc_rdata != previous retirement's pc_wdata, unless rvfi_intr is set on that lane. The previous retirement is the earlier valid lane in the same cycle, or the last registered lane. The check is skipped on the very first retirement.
  - 3 LANE_GAP: valid lanes are not contiguous from lane 0, e.g. 4'b0101.
  - 4 POST_HALT: valid lane seen while HALTED, or any valid lane above a halt lane in the same cycle.
  - 5 TIMEOUT: watchdog reaches TIMEOUT.
  - 6 PC_ALIGN: pc_wdata misaligned on a non-trap lane. Misaligned means bit0 set with COMPRESSED=1, or bits[1:0] nonzero with COMPRESSED=0.
- Simultaneous failures: lowest code wins. Within a code, the lowest lane wins. err_order is the failing lane's order.
- Latency: err, err_code and err_order are registered and assert the cycle after the offending inputs. Once err=1 they never change until reset.
- The cycle that detects an error still updates retired. Further retirements are not counted.
- Bookkeeping on each non-error cycle with k valid lanes:
  - exp_order += k
  - retired += k
  - last pc_wdata is taken from the highest valid lane
- Watchdog:
  - Cleared on any valid lane.
  - Otherwise increments, saturating at TIMEOUT.
  - Counting happens in RUN only.
- Wrap-around: order, retired and exp_order are 64-bit and wrap modulo 2^64. A wrap is not an error.
- Trapping instructions: PC_CHAIN and ORDER still apply. PC_ALIGN is skipped.
- Reset mid-operation: asynchronous clear as above. The first valid retirement afterwards re-enters RUN with order checked against 0.

Optional Feature:
- Macro: RVFI_MON_ASSERT_EN.
- When defined: an immediate assert(!err_next) in an always_comb block, so formal runs fail at the offending cycle. A cover on the HALTED state is also generated.
- When undefined: no assert or cover statements. The block is synthesizable-style and only flags via the outputs.

Decomposition:
- Package rvfi_mon_pkg holds:
  - typedef enum logic [1:0] mon_state_t {IDLE, RUN, HALTED, ERROR}
  - typedef enum logic [2:0] err_code_t {NONE, ORDER, PC_CHAIN, LANE_GAP, POST_HALT, TIMEOUT, PC_ALIGN}
  - localparam ORDER_W = 64
- Sub-module rvfi_mon_lane_check: combinational per-lane check. Inputs are lane signals, expected order, previous pc_wdata and the COMPRESSED parameter. Outputs are per-code fail bits. It is instantiated NRET times in a generate loop, and the parent chains prev pc between lanes.

Test Plan:
- NRET=1: 10 retirements at orders 0..9, PC 0x0, 0x4, ... chained → err=0, retired=10.
- NRET=1: order sequence 0,1,3 → err=1 one cycle after order 3, err_code=1, err_order=3.
- NRET=2, COMPRESSED=1: lane0 pc_wdata=0x102 and lane1 pc_rdata=0x104 → err_code=2 with err_order of lane1. Repeat with lane1 rvfi_intr=1 → no error.
- NRET=4: valid=4'b0101 → err_code=3. In the same cycle, lane2 order mismatch → err_code=1 wins.
- NRET=1: halt on order 5, then valid at order 6 → err_code=4, err_order=6. Halt only, then idle for 200 cycles with TIMEOUT=64 → err=0.
- TIMEOUT=64: one retirement, then no retirement → err_code=5 exactly 65 cycles later. Pulse reset_n low between clock edges mid-run → outputs zero immediately, next order 0 accepted.
